// File: rtl/ram_dma_arbiter_pkg.sv
// ram_dma_arbiter_pkg
//    Shared definitions for the RAM/DMA arbiter:
//    - CPU bus operation codes (cpu_io_op)
//    - microcycle codes (cpu_mc); the normal order is C1 > C2 > C3 > C4
//    - arbiter FSM state type
package ram_dma_arbiter_pkg;

   localparam logic [1:0] IO_OP_NOP   = 2'b00;
   localparam logic [1:0] IO_OP_WRITE = 2'b01;
   localparam logic [1:0] IO_OP_READ  = 2'b10;
   localparam logic [1:0] IO_OP_FETCH = 2'b11;

   localparam logic [2:0] MC_C1 = 3'd6;
   localparam logic [2:0] MC_C2 = 3'd7;
   localparam logic [2:0] MC_C3 = 3'd5;
   localparam logic [2:0] MC_C4 = 3'd4;

   // IDLE: no request held
   // PEND: request latched, waiting for a free RAM slot
   // CAPT: RAM was driven for the request last cycle; read data is on ram_rdata now
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PEND = 2'd1,
      ST_CAPT = 2'd2
   } dma_state_t;

endpackage

// File: rtl/ram_dma_arbiter_ram_port_mux.sv
// ram_port_mux
//    Combinational slot decode and RAM port select for the arbiter.
//    A DMA access may only use the MC=4 microcycle, or MC=7 when the CPU is not
//    touching RAM in that microcycle (and the idle slot is enabled). Everything
//    else belongs to the CPU, so the CPU never sees a stolen cycle.
// Ports
//    rst          in   asynchronous reset; gates ram_we so nothing is written while held
//    pend         in   a DMA request is latched and waiting for a slot
//    req_we       in   latched DMA write flag
//    req_addr     in   latched DMA address
//    req_wdata    in   latched DMA write data
//    cpu_addr     in   CPU address
//    cpu_wdata    in   CPU write data
//    cpu_io_op    in   CPU bus operation
//    cpu_mc       in   CPU microcycle
//    cpu_ram_sel  in   decoder RAM chip select
//    slot_hit     out  DMA owns the RAM port this cycle
//    ram_we       out  RAM write enable
//    ram_addr     out  RAM address
//    ram_wdata    out  RAM write data
module ram_port_mux
   import ram_dma_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH    = 15,
   parameter int DATA_WIDTH    = 8,
   parameter int USE_IDLE_SLOT = 1
) (
   input  logic                  rst,
   input  logic                  pend,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   input  logic [1:0]            cpu_io_op,
   input  logic [2:0]            cpu_mc,
   input  logic                  cpu_ram_sel,
   output logic                  slot_hit,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata
);

   logic slot_a;
   logic slot_b;
   logic cpu_we;
   logic we_sel;

   always_comb begin
      slot_a = (cpu_mc == MC_C4);
      // MC=7 is only free when the CPU microcycle does not use RAM at all.
      slot_b = (USE_IDLE_SLOT != 0) && (cpu_mc == MC_C2) &&
               (!cpu_ram_sel || (cpu_io_op == IO_OP_NOP));
      slot_hit = pend && (slot_a || slot_b);
      cpu_we   = cpu_ram_sel && (cpu_io_op == IO_OP_WRITE) && (cpu_mc == MC_C2);

      if (slot_hit) begin
         we_sel    = req_we;
         ram_addr  = req_addr;
         ram_wdata = req_wdata;
      end else begin
         we_sel    = cpu_we;
         ram_addr  = cpu_addr;
         ram_wdata = cpu_wdata;
      end
      // Reset must block any write, including one half-way through a cycle.
      ram_we = we_sel && !rst;
   end

endmodule

// File: rtl/ram_dma_arbiter.sv
// ram_dma_arbiter
//    Shares the single-port main RAM between the CPU (strict priority, never
//    stalled) and one DMA requester. A DMA request is latched, serviced in the
//    first free slot, and completed with a one-cycle dma_ack pulse one cycle
//    after the RAM returns data.
// Ports
//    clk, rst                          clock, asynchronous active-high reset
//    cpu_addr/wdata/io_op/mc/ram_sel   CPU bus and decoder chip select
//    dma_req/we/addr/wdata             DMA request, held until dma_ack
//    dma_ack                           one-cycle completion pulse
//    dma_rdata                         read data, valid with dma_ack and held
//    dma_busy                          request latched and not yet acked
//    ram_we/addr/wdata, ram_rdata      RAM port (synchronous read, 1-cycle latency)
//    grant_count                       number of DMA slots issued, wrapping
module ram_dma_arbiter
   import ram_dma_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH    = 15,
   parameter int DATA_WIDTH    = 8,
   parameter int USE_IDLE_SLOT = 1,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   input  logic [1:0]            cpu_io_op,
   input  logic [2:0]            cpu_mc,
   input  logic                  cpu_ram_sel,
   input  logic                  dma_req,
   input  logic                  dma_we,
   input  logic [ADDR_WIDTH-1:0] dma_addr,
   input  logic [DATA_WIDTH-1:0] dma_wdata,
   output logic                  dma_ack,
   output logic [DATA_WIDTH-1:0] dma_rdata,
   output logic                  dma_busy,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic [CNT_WIDTH-1:0]  grant_count
);

   dma_state_t            state_reg,  state_next;
   logic                  req_we_reg, req_we_next;
   logic [ADDR_WIDTH-1:0] req_addr_reg, req_addr_next;
   logic [DATA_WIDTH-1:0] req_wdata_reg, req_wdata_next;
   logic                  busy_reg,   busy_next;
   logic                  ack_reg,    ack_next;
   logic [DATA_WIDTH-1:0] rdata_reg,  rdata_next;
   logic [CNT_WIDTH-1:0]  count_reg,  count_next;
   logic                  slot_hit;

   ram_port_mux #(
      .ADDR_WIDTH    (ADDR_WIDTH),
      .DATA_WIDTH    (DATA_WIDTH),
      .USE_IDLE_SLOT (USE_IDLE_SLOT)
   ) u_mux (
      .rst         (rst),
      .pend        (state_reg == ST_PEND),
      .req_we      (req_we_reg),
      .req_addr    (req_addr_reg),
      .req_wdata   (req_wdata_reg),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_io_op   (cpu_io_op),
      .cpu_mc      (cpu_mc),
      .cpu_ram_sel (cpu_ram_sel),
      .slot_hit    (slot_hit),
      .ram_we      (ram_we),
      .ram_addr    (ram_addr),
      .ram_wdata   (ram_wdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         req_we_reg    <= 1'b0;
         req_addr_reg  <= '0;
         req_wdata_reg <= '0;
         busy_reg      <= 1'b0;
         ack_reg       <= 1'b0;
         rdata_reg     <= '0;
         count_reg     <= '0;
      end else begin
         state_reg     <= state_next;
         req_we_reg    <= req_we_next;
         req_addr_reg  <= req_addr_next;
         req_wdata_reg <= req_wdata_next;
         busy_reg      <= busy_next;
         ack_reg       <= ack_next;
         rdata_reg     <= rdata_next;
         count_reg     <= count_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      req_we_next    = req_we_reg;
      req_addr_next  = req_addr_reg;
      req_wdata_next = req_wdata_reg;
      busy_next      = busy_reg;
      ack_next       = 1'b0;
      rdata_next     = rdata_reg;
      count_next     = count_reg;

      case (state_reg)
         ST_IDLE: begin
            // The requester still holds dma_req during the ack cycle; ignore it
            // there so the finished request is not accepted twice.
            if (dma_req && !ack_reg) begin
               req_we_next    = dma_we;
               req_addr_next  = dma_addr;
               req_wdata_next = dma_wdata;
               busy_next      = 1'b1;
               state_next     = ST_PEND;
            end
         end
         ST_PEND: begin
            if (slot_hit) begin
               count_next = count_reg + CNT_WIDTH'(1);
               state_next = ST_CAPT;
            end
         end
         ST_CAPT: begin
            if (!req_we_reg) begin
               rdata_next = ram_rdata;
            end
            ack_next   = 1'b1;
            busy_next  = 1'b0;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign dma_ack     = ack_reg;
   assign dma_busy    = busy_reg;
   assign dma_rdata   = rdata_reg;
   assign grant_count = count_reg;

endmodule

// File: tb/tb_ram_dma_arbiter.sv
// Bench for ram_dma_arbiter. Two instances share one CPU bus: "dut" uses the
// idle slot and an 8-bit grant counter (so wrap-around is reachable), "dut2"
// has the idle slot disabled. Each instance has its own RAM array.
module tb_ram_dma_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [14:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic [1:0]  cpu_io_op;
   logic [2:0]  cpu_mc;
   logic        cpu_ram_sel;

   logic        dma_req, dma_we, dma_ack, dma_busy, ram_we;
   logic [14:0] dma_addr, ram_addr;
   logic [7:0]  dma_wdata, dma_rdata, ram_wdata, ram_rdata;
   logic [7:0]  grant_count;

   logic        dma2_req, dma2_we, dma2_ack, dma2_busy, ram2_we;
   logic [14:0] dma2_addr, ram2_addr;
   logic [7:0]  dma2_wdata, dma2_rdata, ram2_wdata, ram2_rdata;
   logic [15:0] grant2_count;

   int vecs = 0;
   int errs = 0;

   logic [7:0] mem  [0:32767];
   logic [7:0] mem2 [0:32767];
   logic [7:0] gmem [0:32767];

   always #5 clk = ~clk;

   ram_dma_arbiter #(.ADDR_WIDTH(15), .DATA_WIDTH(8), .USE_IDLE_SLOT(1), .CNT_WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_io_op(cpu_io_op),
      .cpu_mc(cpu_mc), .cpu_ram_sel(cpu_ram_sel),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_busy(dma_busy),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .grant_count(grant_count)
   );

   ram_dma_arbiter #(.ADDR_WIDTH(15), .DATA_WIDTH(8), .USE_IDLE_SLOT(0), .CNT_WIDTH(16)) dut2 (
      .clk(clk), .rst(rst),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_io_op(cpu_io_op),
      .cpu_mc(cpu_mc), .cpu_ram_sel(cpu_ram_sel),
      .dma_req(dma2_req), .dma_we(dma2_we), .dma_addr(dma2_addr), .dma_wdata(dma2_wdata),
      .dma_ack(dma2_ack), .dma_rdata(dma2_rdata), .dma_busy(dma2_busy),
      .ram_we(ram2_we), .ram_addr(ram2_addr), .ram_wdata(ram2_wdata), .ram_rdata(ram2_rdata),
      .grant_count(grant2_count)
   );

   // Synchronous single-port RAMs, read-before-write.
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end
   always @(posedge clk) begin
      if (ram2_we) mem2[ram2_addr] <= ram2_wdata;
      ram2_rdata <= mem2[ram2_addr];
   end

   function automatic logic [7:0] pat(input int a);
      return 8'((a * 7 + 3) & 255);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // CPU microcycle generator: 6 > 7 > 5 > 4, advancing just after each rising edge.
   initial begin : cpu_gen
      int k;
      k = 0;
      cpu_mc = 3'd6;
      forever begin
         @(posedge clk); #1;
         k = (k + 1) % 4;
         case (k)
            0: cpu_mc = 3'd6;
            1: cpu_mc = 3'd7;
            2: cpu_mc = 3'd5;
            default: cpu_mc = 3'd4;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Behavioural model of "dut": a request is outstanding from acceptance
   // until its ack; it takes the first free slot after acceptance; its result
   // is acked two cycles after the slot. A golden memory follows every write
   // the model predicts, so read data is predicted independently of the DUT.
   // ---------------------------------------------------------------------
   logic        m_busy, m_ack, m_granted, m_we, m_rd_valid;
   logic [14:0] m_addr;
   logic [7:0]  m_wdata, m_rdata, m_grant_rd, m_rd_exp;
   logic [7:0]  m_count;

   initial begin : model
      logic        slot, grant_now, exp_we, acc;
      logic [14:0] exp_addr;
      logic [7:0]  exp_wd, rd;
      m_busy = 0; m_ack = 0; m_granted = 0; m_we = 0; m_addr = 0; m_wdata = 0;
      m_rdata = 0; m_grant_rd = 0; m_count = 0; m_rd_valid = 0; m_rd_exp = 0;
      forever begin
         @(negedge clk);
         grant_now = 1'b0;
         if (rst) begin
            m_busy = 0; m_ack = 0; m_granted = 0; m_rdata = 0; m_count = 0;
            exp_we = 1'b0; exp_addr = cpu_addr; exp_wd = cpu_wdata;
         end else begin
            slot = (cpu_mc == 3'd4) ||
                   ((cpu_mc == 3'd7) && (!cpu_ram_sel || cpu_io_op == 2'b00));
            grant_now = m_busy && !m_granted && slot;
            if (grant_now) begin
               exp_we = m_we; exp_addr = m_addr; exp_wd = m_wdata;
            end else begin
               exp_we   = cpu_ram_sel && (cpu_io_op == 2'b01) && (cpu_mc == 3'd7);
               exp_addr = cpu_addr; exp_wd = cpu_wdata;
            end
         end
         check("ram_we",      ram_we,      exp_we);
         check("ram_addr",    ram_addr,    exp_addr);
         check("ram_wdata",   ram_wdata,   exp_wd);
         check("dma_ack",     dma_ack,     m_ack);
         check("dma_busy",    dma_busy,    m_busy);
         check("dma_rdata",   dma_rdata,   m_rdata);
         check("grant_count", grant_count, m_count);
         if (m_rd_valid) check("ram_rdata", ram_rdata, m_rd_exp);

         rd = gmem[exp_addr];
         if (exp_we) gmem[exp_addr] = exp_wd;
         m_rd_exp   = rd;
         m_rd_valid = 1'b1;

         if (!rst) begin
            acc = !m_busy && !m_ack && dma_req;
            if (m_granted) begin
               if (!m_we) m_rdata = m_grant_rd;
               m_ack = 1'b1; m_busy = 1'b0; m_granted = 1'b0;
            end else begin
               m_ack = 1'b0;
            end
            if (grant_now) begin
               m_granted = 1'b1; m_grant_rd = rd; m_count = m_count + 8'd1;
            end
            if (acc) begin
               m_busy = 1'b1; m_we = dma_we; m_addr = dma_addr; m_wdata = dma_wdata;
            end
         end
      end
   end

   // Monitor for the idle-slot-disabled instance during the 100-read run.
   logic t4_on = 1'b0;
   int   t4_steal = 0, t4_overlap = 0, t4_spacing = 0;
   initial begin : t4_mon
      int   cyc, last_ack;
      logic busy_prev;
      cyc = 0; last_ack = -100; busy_prev = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (t4_on) begin
            if (cpu_mc != 3'd4 && ram2_addr != cpu_addr) t4_steal++;
            if (dma2_ack && dma2_busy) t4_overlap++;
            if (dma2_ack) last_ack = cyc;
            if (dma2_busy && !busy_prev && (cyc - last_ack) < 2) t4_spacing++;
         end
         busy_prev = dma2_busy;
      end
   end

   task automatic cpu_set(input logic sel, input logic [1:0] op,
                          input logic [14:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      cpu_ram_sel = sel; cpu_io_op = op; cpu_addr = a; cpu_wdata = d;
   endtask

   task automatic dma_xfer(input logic we, input logic [14:0] a, input logic [7:0] d,
                           output int lat);
      @(posedge clk); #1;
      dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d;
      lat = 0;
      forever begin
         @(negedge clk);
         if (dma_ack || lat >= 30) break;
         lat++;
      end
      check("ack_seen", dma_ack, 1'b1);
      $display("xfer we=%0d addr=%h wdata=%h rdata=%h latency=%0d count=%h",
               we, a, d, dma_rdata, lat, grant_count);
      @(posedge clk); #1;
      dma_req = 1'b0;
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int lat, n;
      for (int i = 0; i < 32768; i++) begin
         mem[i] = pat(i); mem2[i] = pat(i); gmem[i] = pat(i);
      end
      rst = 1'b1;
      cpu_addr = 15'h7F00; cpu_wdata = 8'h00; cpu_io_op = 2'b11; cpu_ram_sel = 1'b0;
      dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
      dma2_req = 0; dma2_we = 0; dma2_addr = 0; dma2_wdata = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy",  dma_busy,    1'b0);
      check("reset_ack",   dma_ack,     1'b0);
      check("reset_rdata", dma_rdata,   8'h00);
      check("reset_count", grant_count, 8'h00);
      check("reset_we",    ram_we,      1'b0);
      rst = 1'b0;
      repeat (4) @(posedge clk);

      // 1: DMA write while the CPU fetches from ROM.
      dma_xfer(1'b1, 15'h1234, 8'hA5, lat);
      check("t1_latency_in_3_6", (lat >= 3 && lat <= 6), 1'b1);
      repeat (2) @(posedge clk);
      check("t1_mem", mem[15'h1234], 8'hA5);
      check("t1_count", grant_count, 8'h01);

      // 2: DMA read while the CPU reads RAM at 0x0040.
      cpu_set(1'b1, 2'b10, 15'h0040, 8'h00);
      repeat (4) @(posedge clk);
      dma_xfer(1'b0, 15'h0010, 8'h00, lat);
      check("t2_rdata", dma_rdata, 8'h73);
      check("t2_count", grant_count, 8'h02);
      n = 0;
      do begin @(negedge clk); n++; end while (cpu_mc != 3'd5 && n < 8);
      check("t2_cpu_read", ram_rdata, 8'hC3);

      // 3: CPU write at MC=7 alongside a pending DMA write.
      cpu_set(1'b1, 2'b01, 15'h0020, 8'h3C);
      dma_xfer(1'b1, 15'h0021, 8'hC3, lat);
      repeat (5) @(posedge clk);
      check("t3_cpu_byte", mem[15'h0020], 8'h3C);
      check("t3_dma_byte", mem[15'h0021], 8'hC3);
      check("t3_count", grant_count, 8'h03);

      // 4: idle slot disabled, CPU NOPs, 100 back-to-back DMA reads.
      cpu_set(1'b1, 2'b00, 15'h0100, 8'h00);
      t4_on = 1'b1;
      @(posedge clk); #1;
      dma2_we = 1'b0; dma2_addr = 15'h0200; dma2_req = 1'b1;
      for (int i = 0; i < 100; i++) begin
         int w;
         dma2_addr = 15'(32'h200 + i);
         w = 0;
         do begin @(negedge clk); w++; end while (!dma2_ack && w < 40);
         check("t4_ack_seen", dma2_ack, 1'b1);
         check("t4_rdata", dma2_rdata, pat(32'h200 + i));
         $display("xfer2 addr=%h rdata=%h wait=%0d count=%0d", dma2_addr, dma2_rdata, w, grant2_count);
         @(posedge clk); #1;
      end
      dma2_req = 1'b0;
      repeat (3) @(posedge clk);
      t4_on = 1'b0;
      check("t4_count", grant2_count, 16'd100);
      check("t4_steal", t4_steal, 0);
      check("t4_ack_busy_overlap", t4_overlap, 0);
      check("t4_accept_spacing", t4_spacing, 0);

      // 6: grant counter wrap (8-bit counter in this instance).
      cpu_set(1'b0, 2'b11, 15'h7F00, 8'h00);
      n = 0;
      while (grant_count != 8'hFF && n < 300) begin
         dma_xfer(1'b0, 15'(32'h400 + n), 8'h00, lat);
         n++;
      end
      check("t6_count_ff", grant_count, 8'hFF);
      dma_xfer(1'b0, 15'h0500, 8'h00, lat);
      dma_xfer(1'b0, 15'h0501, 8'h00, lat);
      check("t6_count_wrap", grant_count, 8'h01);
      check("t6_rdata", dma_rdata, pat(32'h0501));

      // 5: reset while a DMA write is pending at MC=7 during a CPU RAM write.
      cpu_set(1'b1, 2'b01, 15'h0030, 8'h77);
      repeat (8) @(posedge clk);
      n = 0;
      do begin @(negedge clk); n++; end while (cpu_mc != 3'd5 && n < 8);
      @(posedge clk); #1;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 15'h0031; dma_wdata = 8'h99;
      @(negedge clk);
      @(negedge clk);
      check("t5_busy_pend", dma_busy, 1'b1);
      @(negedge clk);
      #1;
      rst = 1'b1; dma_req = 1'b0;
      #1;
      check("t5_rst_busy", dma_busy, 1'b0);
      check("t5_rst_ack",  dma_ack,  1'b0);
      check("t5_rst_we",   ram_we,   1'b0);
      check("t5_rst_count", grant_count, 8'h00);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      cpu_set(1'b0, 2'b11, 15'h7F00, 8'h00);
      repeat (10) @(posedge clk);
      #1;
      check("t5_no_write", mem[15'h0031], 8'h5A);
      check("t5_idle_busy", dma_busy, 1'b0);
      check("t5_count_after", grant_count, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
